// File: rtl/nco_cfo_compensator_mc_if.sv
// Bundle of the I/Q stream (in and out) and the AXI4-Lite control port.
// No latency of its own; wires only.
// Handshake semantics are owned by the attached slave (the compensator).
interface nco_cfo_compensator_mc_if #(
    parameter int AXIS_DATA_WIDTH  = 96,
    parameter int AXIS_TUSER_WIDTH = 1
);
    logic [AXIS_DATA_WIDTH-1:0]  s_axis_tdata;
    logic [AXIS_TUSER_WIDTH-1:0] s_axis_tuser;
    logic                        s_axis_tvalid;
    logic                        s_axis_tlast;
    logic                        s_axis_tready;

    logic [AXIS_DATA_WIDTH-1:0]  m_axis_tdata;
    logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
    logic                        m_axis_tvalid;
    logic                        m_axis_tlast;
    logic                        m_axis_tready;

    logic        s_axi_awvalid;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awready;
    logic        s_axi_wvalid;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wready;
    logic        s_axi_bvalid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bready;
    logic        s_axi_arvalid;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arready;
    logic        s_axi_rvalid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rready;

    // Compensator side.
    modport slave (
        input  s_axis_tdata, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        input  s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );

    // Stream source / sink and CPU side.
    modport master (
        output s_axis_tdata, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        output s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );
endinterface

// File: rtl/nco_cfo_compensator_mc.sv
// N-channel I/Q derotator by a shared NCO phase (x*e^-j0 or x*e^+j0), AXI-Lite controlled.
// Latency: m_axis_tvalid 2*N+2 cycles after accept; one beat per 2*N+3 cycles at best.
// Backpressure: one beat computing, one held; s_axis_tready low outside IDLE, nothing dropped.
module nco_cfo_compensator_mc #(
    parameter int WIDTH            = 12,
    parameter int NUM_CHANNELS     = 4,
    parameter int AXIS_DATA_WIDTH  = NUM_CHANNELS*2*WIDTH,
    parameter int AXIS_TUSER_WIDTH = 1,
    parameter int ACC_WIDTH        = 32,
    parameter int LUT_ADDR_WIDTH   = 8,
    parameter int LUT_DATA_WIDTH   = 16
) (
    input logic clk,
    input logic rst,
    nco_cfo_compensator_mc_if.slave io_bus
);
    localparam int  LUT_SIZE = 1 << LUT_ADDR_WIDTH;
    localparam int  F        = LUT_DATA_WIDTH - 1;
    localparam int  PW       = WIDTH + LUT_DATA_WIDTH;
    localparam int  SW       = PW + 1;
    localparam int  STEPS    = 2*NUM_CHANNELS;
    localparam int  STEP_W   = $clog2(STEPS);
    localparam int  IDXW     = $clog2(AXIS_DATA_WIDTH);
    localparam real PI       = 3.14159265358979323846;
    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (F-1);
    localparam logic signed [SW-1:0] OMAX = (SW'(1) <<< (WIDTH-1)) - SW'(1);
    localparam logic signed [SW-1:0] OMIN = -(SW'(1) <<< (WIDTH-1));
    localparam logic [WIDTH-1:0]     WMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     WMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LUT, MUL, HOLD} state_t;
    state_t r_state, w_state_nxt;

    // Full-wave tables, scaled by 2^F-1 and truncated toward zero.
    logic signed [LUT_DATA_WIDTH-1:0] w_cos_tab [LUT_SIZE];
    logic signed [LUT_DATA_WIDTH-1:0] w_sin_tab [LUT_SIZE];
    for (genvar g = 0; g < LUT_SIZE; g++) begin : g_lut
        localparam real ANG   = 2.0 * PI * real'(g) / real'(LUT_SIZE);
        localparam real AMP   = real'((1 << F) - 1);
        localparam int  COS_V = $rtoi($cos(ANG) * AMP);
        localparam int  SIN_V = $rtoi($sin(ANG) * AMP);
        assign w_cos_tab[g] = LUT_DATA_WIDTH'(COS_V);
        assign w_sin_tab[g] = LUT_DATA_WIDTH'(SIN_V);
    end

    logic [31:0] r_inc, r_offset, r_sat_cnt, r_rdata;
    logic [2:0]  r_ctrl;
    logic        r_awready, r_bvalid, r_arready, r_rvalid;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [AXIS_DATA_WIDTH-1:0]  r_dat, r_res, r_m_dat;
    logic [AXIS_TUSER_WIDTH-1:0] r_user, r_m_user;
    logic        r_last, r_conj, r_bypass, r_m_vld, r_m_last, r_s_tready;
    logic [LUT_ADDR_WIDTH-1:0] r_idx;
    logic signed [LUT_DATA_WIDTH-1:0] r_cos, r_sin;
    logic [STEP_W-1:0] r_step;

    logic        w_wr, w_rd, w_accept, w_sof, w_hold_go, w_sat_clr, w_sat_inc;
    logic        w_sel_im, w_sub, w_clip;
    logic [31:0] w_rd_val;
    logic [ACC_WIDTH-1:0] w_phase, w_phase_sum;
    logic [LUT_ADDR_WIDTH-1:0] w_idx;
    logic [IDXW-1:0] w_ch_base, w_rbase;
    logic signed [WIDTH-1:0] w_i, w_q, w_a0, w_a1;
    logic signed [PW-1:0] w_p0, w_p1;
    logic signed [SW-1:0] w_sum, w_rsum, w_rnd;
    logic [WIDTH-1:0] w_val;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
        return v;
    endfunction

    assign w_wr      = r_awready && io_bus.s_axi_awvalid && io_bus.s_axi_wvalid;
    assign w_rd      = r_arready && io_bus.s_axi_arvalid;
    assign w_sat_clr = w_wr && (io_bus.s_axi_awaddr == 4'hC);
    assign w_accept  = (r_state == IDLE) && r_s_tready && io_bus.s_axis_tvalid;
    assign w_hold_go = (r_state == HOLD) && (!r_m_vld || io_bus.m_axis_tready);
    assign w_sof     = r_ctrl[2] && io_bus.s_axis_tuser[0];
    assign w_phase     = w_sof ? '0 : r_acc;
    assign w_phase_sum = w_phase + r_offset[ACC_WIDTH-1:0];
    assign w_idx       = LUT_ADDR_WIDTH'(w_phase_sum >> (ACC_WIDTH - LUT_ADDR_WIDTH));

    // Register read mux; misaligned or unmapped addresses read zero.
    always_comb begin
        w_rd_val = '0;
        case (io_bus.s_axi_araddr)
            4'h0:    w_rd_val = r_inc;
            4'h4:    w_rd_val = r_offset;
            4'h8:    w_rd_val = {29'b0, r_ctrl};
            4'hC:    w_rd_val = r_sat_cnt;
            default: w_rd_val = '0;
        endcase
    end

    // AXI-Lite handshakes and the control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awready <= 1'b0; r_bvalid <= 1'b0; r_arready <= 1'b0; r_rvalid <= 1'b0;
            r_rdata <= '0; r_inc <= '0; r_offset <= '0; r_ctrl <= '0;
        end else begin
            r_awready <= !r_awready && io_bus.s_axi_awvalid && io_bus.s_axi_wvalid && !r_bvalid;
            r_arready <= !r_arready && io_bus.s_axi_arvalid && !r_rvalid;
            if (w_wr) r_bvalid <= 1'b1;
            else if (io_bus.s_axi_bready) r_bvalid <= 1'b0;
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_val;
            end else if (io_bus.s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_wr) begin
                case (io_bus.s_axi_awaddr)
                    4'h0: r_inc    <= strb_merge(r_inc, io_bus.s_axi_wdata, io_bus.s_axi_wstrb);
                    4'h4: r_offset <= strb_merge(r_offset, io_bus.s_axi_wdata, io_bus.s_axi_wstrb);
                    4'h8: if (io_bus.s_axi_wstrb[0]) r_ctrl <= io_bus.s_axi_wdata[2:0];
                    default: ;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: one beat walks IDLE -> LUT -> MUL (2 steps per channel) -> HOLD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LUT;
            LUT:     w_state_nxt = MUL;
            MUL:     if (r_step == STEP_W'(STEPS-1)) w_state_nxt = HOLD;
            HOLD:    if (w_hold_go) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Even steps produce re (I*c, Q*s), odd steps im (Q*c, I*s) on the two shared multipliers.
    always_comb begin
        w_sel_im  = r_step[0];
        w_ch_base = IDXW'(int'(r_step >> 1) * 2 * WIDTH);
        w_rbase   = w_sel_im ? w_ch_base + IDXW'(WIDTH) : w_ch_base;
        w_i       = r_dat[w_ch_base +: WIDTH];
        w_q       = r_dat[w_ch_base + IDXW'(WIDTH) +: WIDTH];
        w_a0      = w_sel_im ? w_q : w_i;
        w_a1      = w_sel_im ? w_i : w_q;
        w_p0      = PW'(w_a0) * PW'(r_cos);
        w_p1      = PW'(w_a1) * PW'(r_sin);
        w_sub     = r_conj ^ w_sel_im;
        w_sum     = w_sub ? SW'(w_p0) - SW'(w_p1) : SW'(w_p0) + SW'(w_p1);
        w_rsum    = w_sum + RND;
        w_rnd     = w_rsum >>> F;
        w_clip    = (w_rnd > OMAX) || (w_rnd < OMIN);
        w_val     = w_clip ? ((w_rnd > OMAX) ? WMAX : WMIN) : w_rnd[WIDTH-1:0];
        w_sat_inc = (r_state == MUL) && !r_bypass && w_clip;
    end

    // Beat capture, phase accumulator, LUT lookup and per-step result write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat <= '0; r_user <= '0; r_last <= 1'b0; r_conj <= 1'b0; r_bypass <= 1'b0;
            r_idx <= '0; r_acc <= '0; r_step <= '0; r_cos <= '0; r_sin <= '0; r_res <= '0;
        end else begin
            if (w_accept) begin
                r_dat    <= io_bus.s_axis_tdata;
                r_user   <= io_bus.s_axis_tuser;
                r_last   <= io_bus.s_axis_tlast;
                r_conj   <= r_ctrl[0];
                r_bypass <= r_ctrl[1];
                r_idx    <= w_idx;
                r_acc    <= w_phase + r_inc[ACC_WIDTH-1:0];
                r_step   <= '0;
            end
            if (r_state == LUT) begin
                r_cos <= w_cos_tab[r_idx];
                r_sin <= w_sin_tab[r_idx];
            end
            if (r_state == MUL) begin
                r_step <= r_step + 1'b1;
                if (!r_bypass) r_res[w_rbase +: WIDTH] <= w_val;
            end
        end
    end

    // Saturation counter: sticks at all-ones; a CPU clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || w_sat_clr)                   r_sat_cnt <= '0;
        else if (w_sat_inc && r_sat_cnt != '1)  r_sat_cnt <= r_sat_cnt + 32'd1;
    end

    // Output register: loaded from HOLD, kept stable until the sink takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_vld <= 1'b0; r_m_dat <= '0; r_m_user <= '0; r_m_last <= 1'b0; r_s_tready <= 1'b0;
        end else begin
            r_s_tready <= (w_state_nxt == IDLE);
            if (w_hold_go) begin
                r_m_vld  <= 1'b1;
                r_m_dat  <= r_bypass ? r_dat : r_res;
                r_m_user <= r_user;
                r_m_last <= r_last;
            end else if (io_bus.m_axis_tready) begin
                r_m_vld <= 1'b0;
            end
        end
    end

    assign io_bus.s_axis_tready = r_s_tready;
    assign io_bus.m_axis_tvalid = r_m_vld;
    assign io_bus.m_axis_tdata  = r_m_dat;
    assign io_bus.m_axis_tuser  = r_m_user;
    assign io_bus.m_axis_tlast  = r_m_last;
    assign io_bus.s_axi_awready = r_awready;
    assign io_bus.s_axi_wready  = r_awready;
    assign io_bus.s_axi_bvalid  = r_bvalid;
    assign io_bus.s_axi_bresp   = 2'b00;
    assign io_bus.s_axi_arready = r_arready;
    assign io_bus.s_axi_rvalid  = r_rvalid;
    assign io_bus.s_axi_rdata   = r_rdata;
    assign io_bus.s_axi_rresp   = 2'b00;
endmodule

// File: tb/tb_nco_cfo_compensator_mc.sv
// Directed bench for the N-channel NCO derotator with hand-computed expectations.
// Beats are driven one at a time; latency is measured from the accept edge.
// The sink is held off in dedicated sequences to exercise the hold path.
module tb_nco_cfo_compensator_mc;
    localparam int W  = 12;
    localparam int N  = 4;
    localparam int DW = N*2*W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nco_cfo_compensator_mc_if #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(1)) bus ();

    nco_cfo_compensator_mc #(.WIDTH(W), .NUM_CHANNELS(N)) dut (
        .clk(clk), .rst(rst), .io_bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out", nm);
    endtask

    function automatic logic [DW-1:0] rep(input int i, input int q);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < N; k++) begin
            d[2*W*k +: W]     = W'(i);
            d[2*W*k + W +: W] = W'(q);
        end
        return d;
    endfunction

    function automatic int comp(input logic [DW-1:0] d, input int k, input int im);
        logic signed [W-1:0] x;
        x = d[(2*k + im)*W +: W];
        return int'(x);
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        t = 0;
        while (!bus.s_axi_awready && t < 20) begin @(posedge clk); #1; t++; end
        if (t >= 20) timeout("axi_write awready");
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
        t = 0;
        while (!bus.s_axi_bvalid && t < 20) begin @(posedge clk); #1; t++; end
        if (t >= 20) timeout("axi_write bvalid");
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int t;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        t = 0;
        while (!bus.s_axi_arready && t < 20) begin @(posedge clk); #1; t++; end
        if (t >= 20) timeout("axi_read arready");
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        t = 0;
        while (!bus.s_axi_rvalid && t < 20) begin @(posedge clk); #1; t++; end
        if (t >= 20) timeout("axi_read rvalid");
        d = bus.s_axi_rdata;
        bus.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_rready = 1'b0;
    endtask

    // Returns just after the accept edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
        int t;
        bus.s_axis_tdata = d; bus.s_axis_tuser = u; bus.s_axis_tlast = l; bus.s_axis_tvalid = 1'b1;
        t = 0;
        while (!bus.s_axis_tready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) timeout("send_beat tready");
        @(posedge clk); #1;
        bus.s_axis_tvalid = 1'b0;
    endtask

    // Waits for tvalid, samples the beat; drains it when tready is high.
    task automatic recv_beat(output logic [DW-1:0] d, output logic u, output logic l, output int lat);
        lat = 0;
        while (!bus.m_axis_tvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (lat >= 100) timeout("recv_beat tvalid");
        d = bus.m_axis_tdata; u = bus.m_axis_tuser[0]; l = bus.m_axis_tlast;
        @(posedge clk); #1;
    endtask

    task automatic chk_beat(input string nm, input logic [DW-1:0] d, input int ei, input int eq);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s ch%0d I", nm, k), comp(d, k, 0), ei);
            chk($sformatf("%s ch%0d Q", nm, k), comp(d, k, 1), eq);
        end
    endtask

    typedef struct {
        logic [31:0] off;
        logic [2:0]  ctrl;
        int          i_in, q_in, i_exp, q_exp;
    } vec_t;
    vec_t vt[8];

    logic [DW-1:0] od, hold_dat, rnd_dat;
    logic          ou, ol, acc_now, held;
    logic [31:0]   rd;
    int            lat, n_acc, bi, unstable, late_vld;
    logic [DW-1:0] bp_dat  [3];
    logic          bp_user [3];
    logic          bp_last [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h0000_0000, 3'b000,  1000, -500,  1000, -500};
        vt[1] = '{32'h4000_0000, 3'b000,  1000,    0,     0, -1000};
        vt[2] = '{32'h4000_0000, 3'b001,  1000,    0,     0,  1000};
        vt[3] = '{32'h2000_0000, 3'b000,  2047, 2047,  2047,     0};
        vt[4] = '{32'h8000_0000, 3'b000,  1000, -500, -1000,   500};
        vt[5] = '{32'h0000_0000, 3'b000, -2048, 2047, -2048,  2047};
        vt[6] = '{32'h4000_0000, 3'b010,   123,  -77,   123,   -77};
        vt[7] = '{32'h4000_0000, 3'b000, -2048, -2048, -2048, 2047};

        bus.s_axis_tdata = '0; bus.s_axis_tuser = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_bready = 1'b0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst s_tready", bus.s_axis_tready, 0);
        chk("rst m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst m_tdata", (bus.m_axis_tdata == '0), 1);
        chk("rst awready", bus.s_axi_awready, 0);
        chk("rst bvalid", bus.s_axi_bvalid, 0);
        chk("rst rvalid", bus.s_axi_rvalid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        axi_read(4'h0, rd);  chk("rst PHASE_INC", rd, 0);
        axi_read(4'h8, rd);  chk("rst CTRL", rd, 0);
        axi_write(4'h0, 32'hAABB_CCDD, 4'hF);
        axi_write(4'h0, 32'h1122_3344, 4'b0101);
        axi_read(4'h0, rd);  chk("wstrb merge", rd, 32'hAA22_CC44);
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h2, 32'hFFFF_FFFF, 4'hF);
        axi_read(4'h2, rd);  chk("unmapped read", rd, 0);
        axi_read(4'h0, rd);  chk("unmapped write ignored", rd, 0);

        // Table: INC=0 and acc=0, so phase is OFFSET alone
        for (int v = 0; v < 8; v++) begin
            axi_write(4'h4, vt[v].off, 4'hF);
            axi_write(4'h8, {29'b0, vt[v].ctrl}, 4'hF);
            send_beat(rep(vt[v].i_in, vt[v].q_in), 1'b0, v[0]);
            recv_beat(od, ou, ol, lat);
            chk_beat($sformatf("vec%0d", v), od, vt[v].i_exp, vt[v].q_exp);
            chk($sformatf("vec%0d latency", v), lat, 2*N+2);
            chk($sformatf("vec%0d tlast", v), ol, v[0]);
        end
        axi_read(4'hC, rd);  chk("SAT_COUNT", rd, 8);
        axi_write(4'hC, 32'h0, 4'h0);
        axi_read(4'hC, rd);  chk("SAT_COUNT cleared", rd, 0);

        // Phase stepping and start-of-frame phase reset
        axi_write(4'h4, 32'h0, 4'hF);
        axi_write(4'h8, 32'h0, 4'hF);
        axi_write(4'h0, 32'h0100_0000, 4'hF);
        send_beat(rep(1000, 0), 1'b0, 1'b0); recv_beat(od, ou, ol, lat); chk_beat("step idx0", od, 1000, 0);
        send_beat(rep(1000, 0), 1'b0, 1'b0); recv_beat(od, ou, ol, lat); chk_beat("step idx1", od, 1000, -25);
        send_beat(rep(1000, 0), 1'b0, 1'b0); recv_beat(od, ou, ol, lat); chk_beat("step idx2", od, 999, -49);
        axi_write(4'h8, 32'h4, 4'hF);
        send_beat(rep(1000, 0), 1'b1, 1'b0); recv_beat(od, ou, ol, lat); chk_beat("sof idx0", od, 1000, 0);
        chk("sof tuser", ou, 1);
        send_beat(rep(1000, 0), 1'b0, 1'b1); recv_beat(od, ou, ol, lat); chk_beat("after sof idx1", od, 1000, -25);
        chk("after sof tuser", ou, 0);

        // Backpressure: sink stalled for 30 cycles while three beats are offered
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
        axi_write(4'h0, 32'h0100_0000, 4'hF);
        bp_dat[0] = rep(1000, 0); bp_user[0] = 1'b0; bp_last[0] = 1'b1;
        bp_dat[1] = rep(1000, 0); bp_user[1] = 1'b1; bp_last[1] = 1'b0;
        bp_dat[2] = rep(1000, 0); bp_user[2] = 1'b0; bp_last[2] = 1'b1;
        bus.m_axis_tready = 1'b0;
        bi = 0; n_acc = 0; held = 1'b0; unstable = 0; hold_dat = '0;
        bus.s_axis_tdata = bp_dat[0]; bus.s_axis_tuser = bp_user[0]; bus.s_axis_tlast = bp_last[0];
        bus.s_axis_tvalid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            acc_now = bus.s_axis_tready && bus.s_axis_tvalid;
            @(posedge clk); #1;
            if (acc_now) begin
                n_acc++; bi++;
                if (bi < 3) begin
                    bus.s_axis_tdata = bp_dat[bi]; bus.s_axis_tuser = bp_user[bi]; bus.s_axis_tlast = bp_last[bi];
                end else begin
                    bus.s_axis_tvalid = 1'b0;
                end
            end
            if (bus.m_axis_tvalid) begin
                if (!held) begin
                    held = 1'b1; hold_dat = bus.m_axis_tdata;
                end else if (bus.m_axis_tdata != hold_dat || bus.m_axis_tuser[0] != bp_user[0]) begin
                    unstable++;
                end
            end
        end
        bus.s_axis_tvalid = 1'b0;
        chk("bp accepted", n_acc, 2);
        chk("bp held", held, 1);
        chk("bp stable", unstable, 0);
        bus.m_axis_tready = 1'b1;
        recv_beat(od, ou, ol, lat);
        chk_beat("bp beat0", od, 1000, 0);    chk("bp beat0 tuser", ou, 0); chk("bp beat0 tlast", ol, 1);
        recv_beat(od, ou, ol, lat);
        chk_beat("bp beat1", od, 1000, -25);  chk("bp beat1 tuser", ou, 1); chk("bp beat1 tlast", ol, 0);
        send_beat(bp_dat[2], bp_user[2], bp_last[2]);
        recv_beat(od, ou, ol, lat);
        chk_beat("bp beat2", od, 999, -49);   chk("bp beat2 tuser", ou, 0); chk("bp beat2 tlast", ol, 1);

        // Bypass: bit-exact passthrough with unchanged latency
        axi_write(4'h8, 32'h2, 4'hF);
        rnd_dat = {$urandom, $urandom, $urandom};
        send_beat(rnd_dat, 1'b1, 1'b1);
        recv_beat(od, ou, ol, lat);
        chk("bypass data", (od == rnd_dat), 1);
        chk("bypass latency", lat, 2*N+2);
        chk("bypass tuser", ou, 1);

        // Reset while a beat is in MUL and another is held at the output
        axi_write(4'h8, 32'h0, 4'hF);
        bus.m_axis_tready = 1'b0;
        send_beat(rep(500, 500), 1'b0, 1'b0);
        recv_beat(od, ou, ol, lat);
        send_beat(rep(500, 500), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-rst m_tvalid", bus.m_axis_tvalid, 0);
        chk("mid-rst s_tready", bus.s_axis_tready, 0);
        chk("mid-rst m_tdata", (bus.m_axis_tdata == '0), 1);
        chk("mid-rst arready", bus.s_axi_arready, 0);
        rst = 1'b0;
        bus.m_axis_tready = 1'b1;
        late_vld = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.m_axis_tvalid) late_vld++;
        end
        chk("discarded beat", late_vld, 0);
        axi_read(4'h0, rd);  chk("post-rst PHASE_INC", rd, 0);
        axi_write(4'h0, 32'h0100_0000, 4'hF);
        send_beat(rep(1000, 0), 1'b0, 1'b0); recv_beat(od, ou, ol, lat); chk_beat("post-rst idx0", od, 1000, 0);
        send_beat(rep(1000, 0), 1'b0, 1'b0); recv_beat(od, ou, ol, lat); chk_beat("post-rst idx1", od, 1000, -25);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
